ifetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the DLX pipeline. It owns the program counter, drives the combinational instruction memory read address, and buffers fetched {pc, instruction} pairs in a small FIFO toward decode with a valid/ready handshake. It also applies branch/jump redirects with a flush, and halts on misaligned or out-of-range fetch addresses.

---
 rtl/ifetch_pkg.sv | 16 +
 rtl/ifetch_fifo.sv | 65 ++++++
 rtl/ifetch_ctrl.sv | 115 +++++++++++
 tb/tb_ifetch_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the DLX instruction-fetch sequencer.
package ifetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/ifetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with single-cycle flush.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  fetch_entry_t     din,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Storage is cleared on reset so the head reads as zero before the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: PC, imem address, fetch FIFO, redirect and halt.
// Optional IFETCH_STATS_EN adds push and full-stall counters.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 2,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
`ifdef IFETCH_STATS_EN
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_stall,
`endif
    output logic        fault
);

    localparam int          CNT_W = $clog2(DEPTH + 1);
    localparam logic [32:0] LIMIT = 33'(INSTR_BYTES * IMEM_WORDS);

    state_t           state, state_nxt;
    logic [31:0]      pc, pc_nxt;
    logic [CNT_W-1:0] count;
    logic             push, pop, flush;
    logic             redirect_bad;
    logic [32:0]      seq_pc;
    fetch_entry_t     head;

    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign fault     = (state == HALT);

    // 33-bit arithmetic so the range check sees the carry before any wrap.
    assign seq_pc       = {1'b0, pc} + 33'(INSTR_BYTES);
    assign redirect_bad = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        if (redirect_valid) begin
            flush     = 1'b1;
            pc_nxt    = redirect_pc;
            state_nxt = redirect_bad ? HALT : RUN;
        end else begin
            pop = out_valid && out_ready;
            if (state == RUN && ((count < CNT_W'(DEPTH)) || pop)) begin
                push   = 1'b1;
                pc_nxt = seq_pc[31:0];
                if (seq_pc >= LIMIT) begin
                    state_nxt = HALT;
                end
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   ('{pc: pc, instr: imem_instr}),
        .head  (head),
        .count (count)
    );

`ifdef IFETCH_STATS_EN
    logic stall;

    // A RUN cycle without redirect that does not push can only be a full FIFO.
    assign stall = (state == RUN) && !redirect_valid && !push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_stall   <= '0;
        end else begin
            if (push && (stat_fetched != '1)) begin
                stat_fetched <= stat_fetched + 1'b1;
            end
            if (stall && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios then random traffic vs a queue model.
module tb_ifetch_ctrl;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          DEPTH      = 2;
    localparam int          IMEM_WORDS = 256;
    localparam longint      MEM_BYTES  = 4 * IMEM_WORDS;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;
`ifdef IFETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_stall;
`endif

    logic [31:0] mem [IMEM_WORDS];

    typedef struct {
        longint      pc;
        logic [31:0] instr;
    } entry_t;

    entry_t mq[$];
    longint m_pc;
    bit     m_halt;
    longint m_fetched;
    longint m_stall;

    int checks;
    int passes;

    ifetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .DEPTH      (DEPTH),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
`ifdef IFETCH_STATS_EN
        .stat_fetched   (stat_fetched),
        .stat_stall     (stat_stall),
`endif
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr = ({1'b0, imem_addr} < 33'(MEM_BYTES)) ? mem[imem_addr[9:2]] : 32'h0;

    function automatic logic [31:0] mem_word(input longint addr);
        return (addr < MEM_BYTES) ? mem[int'(addr / 4)] : 32'h0;
    endfunction

    function automatic bit bad_target(input longint t);
        return (t % 4 != 0) || (t >= MEM_BYTES);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = longint'(RESET_PC);
        m_halt    = 1'b0;
        m_fetched = 0;
        m_stall   = 0;
    endtask

    // One clock of spec behaviour: redirect wins, else pop then push into the queue.
    task automatic model_edge();
        bit pop_now;
        bit can_push;
        entry_t e;
        pop_now = (mq.size() > 0) && out_ready;
        if (redirect_valid) begin
            mq.delete();
            m_pc   = longint'(redirect_pc);
            m_halt = bad_target(m_pc);
        end else begin
            can_push = !m_halt && ((mq.size() < DEPTH) || pop_now);
            if (pop_now) void'(mq.pop_front());
            if (can_push) begin
                e.pc    = m_pc;
                e.instr = mem_word(m_pc);
                mq.push_back(e);
                m_pc += 4;
                m_fetched++;
                if (m_pc >= MEM_BYTES) m_halt = 1'b1;
            end else if (!m_halt) begin
                m_stall++;
            end
        end
    endtask

    task automatic checkOutput();
        check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
        if (mq.size() > 0) begin
            check("out_pc", out_pc, mq[0].pc[31:0]);
            check("out_instr", out_instr, mq[0].instr);
        end
        check("imem_addr", imem_addr, m_pc[31:0]);
        check("fault", {31'b0, fault}, {31'b0, m_halt});
`ifdef IFETCH_STATS_EN
        check("stat_fetched", stat_fetched, m_fetched[31:0]);
        check("stat_stall", stat_stall, m_stall[31:0]);
`endif
    endtask

    task automatic applyStimulus(input bit rdy, input bit rv, input logic [31:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        model_edge();
        #1;
        checkOutput();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h0022_1820;
        mem[1] = 32'h0022_1822;
        mem[2] = 32'h0022_1824;
        mem[7] = 32'h1022_0010;

        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        #2;
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        // Backpressure then release
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        // Redirect while full
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h1C);
        applyStimulus(1'b0, 1'b0, 32'h0);
        check("redir_head_pc", out_pc, 32'h1C);
        check("redir_head_instr", out_instr, 32'h1022_0010);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        // Misaligned redirect then recovery
        applyStimulus(1'b1, 1'b1, 32'h1E);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        // End of memory
        applyStimulus(1'b1, 1'b1, 32'h3F8);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        check("eom_fault", {31'b0, fault}, 32'h1);
        // Reset mid-stream with a full FIFO
        applyStimulus(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst_out_valid", {31'b0, out_valid}, 32'h0);
        check("midrst_imem_addr", imem_addr, RESET_PC);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0: tgt = $urandom_range(0, 255) * 4;
                1: tgt = 32'h3F0 + $urandom_range(0, 3) * 4;
                2: tgt = $urandom_range(0, 1023);
                default: tgt = 32'h400 + $urandom_range(0, 64);
            endcase
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), tgt);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
